// File: rtl/axis_demux_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// axis_demux_pkg : shared types for the 1-to-2 AXI-Stream demultiplexer
// Revision 1.0   : initial release
// ----------------------------------------------------------------------------
package axis_demux_pkg;

    localparam int DEF_DATAW = 24;

    // The forwarding states double as the route encoding (port 0, port 1, drop).
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FWD0 = 2'd1,
        ST_FWD1 = 2'd2,
        ST_DROP = 2'd3
    } state_e;

    typedef struct packed {
        logic [DEF_DATAW-1:0]   tdata;
        logic                   tuser;
        logic                   tlast;
        logic [DEF_DATAW/8-1:0] tstrb;
        logic [DEF_DATAW/8-1:0] tkeep;
        logic                   tid;
        logic                   tdest;
    } beat_t;

    function automatic int beat_width(input int dataw);
        return dataw + 2 * (dataw / 8) + 4;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axis_skid_buf.sv
`default_nettype none
// ----------------------------------------------------------------------------
// axis_skid_buf : 2-entry skid buffer with registered valid and ready
// Revision 1.0  : initial release
// ----------------------------------------------------------------------------
module axis_skid_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid_i,
    output logic             s_ready_o,
    input  logic [WIDTH-1:0] s_data_i,
    output logic             m_valid_o,
    input  logic             m_ready_i,
    output logic [WIDTH-1:0] m_data_o
);

    logic [1:0]       count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    logic             push, pop;

    assign s_ready_o = (count_q != 2'd2);
    assign m_valid_o = (count_q != 2'd0);
    assign m_data_o  = head_q;
    assign push      = s_valid_i & s_ready_o;
    assign pop       = m_valid_o & m_ready_i;

    // Push-and-pop can only happen with exactly one entry held.
    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case ({push, pop})
            2'b10: begin
                if (count_q == 2'd0) head_d = s_data_i;
                else                 tail_d = s_data_i;
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                head_d  = tail_q;
                count_d = count_q - 2'd1;
            end
            2'b11:   head_d = s_data_i;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 2'd0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/axis_demux_1x2.sv
`default_nettype none
// ----------------------------------------------------------------------------
// axis_demux_1x2 : packet-level AXI-Stream 1-to-2 demux with drop and counter
// Revision 1.0   : initial release
// ----------------------------------------------------------------------------
module axis_demux_1x2
    import axis_demux_pkg::*;
#(
    parameter int DATAW = DEF_DATAW
) (
    input  logic               aclk,
    input  logic               aresetn,
    input  logic               sel,
    input  logic               m0_en,
    input  logic               m1_en,

    input  logic [DATAW-1:0]   s_axis_tdata,
    input  logic               s_axis_tvalid,
    output logic               s_axis_tready,
    input  logic               s_axis_tuser,
    input  logic               s_axis_tlast,
    input  logic [DATAW/8-1:0] s_axis_tstrb,
    input  logic [DATAW/8-1:0] s_axis_tkeep,
    input  logic               s_axis_tid,
    input  logic               s_axis_tdest,

    output logic [DATAW-1:0]   m0_axis_tdata,
    output logic               m0_axis_tvalid,
    input  logic               m0_axis_tready,
    output logic               m0_axis_tuser,
    output logic               m0_axis_tlast,
    output logic [DATAW/8-1:0] m0_axis_tstrb,
    output logic [DATAW/8-1:0] m0_axis_tkeep,
    output logic               m0_axis_tid,
    output logic               m0_axis_tdest,

    output logic [DATAW-1:0]   m1_axis_tdata,
    output logic               m1_axis_tvalid,
    input  logic               m1_axis_tready,
    output logic               m1_axis_tuser,
    output logic               m1_axis_tlast,
    output logic [DATAW/8-1:0] m1_axis_tstrb,
    output logic [DATAW/8-1:0] m1_axis_tkeep,
    output logic               m1_axis_tid,
    output logic               m1_axis_tdest,

    output logic               busy,
    output logic [15:0]        drop_cnt
);

    localparam int BEAT_W = beat_width(DATAW);

    typedef struct packed {
        logic [DATAW-1:0]   tdata;
        logic               tuser;
        logic               tlast;
        logic [DATAW/8-1:0] tstrb;
        logic [DATAW/8-1:0] tkeep;
        logic               tid;
        logic               tdest;
    } beat_s;

    state_e      state_q, state_d;
    state_e      route;
    logic [15:0] drop_q, drop_d;
    logic        live_q;
    logic        accept;
    logic        b0_ready, b1_ready;
    logic        b0_push, b1_push;
    beat_s       s_beat, m0_beat, m1_beat;

    assign s_beat = '{tdata: s_axis_tdata, tuser: s_axis_tuser, tlast: s_axis_tlast,
                      tstrb: s_axis_tstrb, tkeep: s_axis_tkeep, tid: s_axis_tid,
                      tdest: s_axis_tdest};

    // Route is live only between packets; afterwards the state carries it.
    always_comb begin
        route = state_q;
        if (state_q == ST_IDLE) begin
            if (!sel && m0_en)     route = ST_FWD0;
            else if (sel && m1_en) route = ST_FWD1;
            else                   route = ST_DROP;
        end
    end

    always_comb begin
        s_axis_tready = 1'b0;
        if (live_q) begin
            case (route)
                ST_FWD0: s_axis_tready = b0_ready;
                ST_FWD1: s_axis_tready = b1_ready;
                default: s_axis_tready = 1'b1;
            endcase
        end
    end

    assign accept  = s_axis_tvalid & s_axis_tready;
    assign b0_push = accept & (route == ST_FWD0);
    assign b1_push = accept & (route == ST_FWD1);
    assign busy    = (state_q != ST_IDLE);
    assign drop_cnt = drop_q;

    always_comb begin
        state_d = state_q;
        drop_d  = drop_q;
        if (accept) begin
            if (state_q == ST_IDLE) begin
                if (!s_axis_tlast) state_d = route;
            end else if (s_axis_tlast) begin
                state_d = ST_IDLE;
            end
            if (s_axis_tlast && route == ST_DROP && drop_q != 16'hFFFF)
                drop_d = drop_q + 16'd1;
        end
    end

    // live_q holds the slave side not-ready through reset and its release edge.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= ST_IDLE;
            drop_q  <= 16'd0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            drop_q  <= drop_d;
            live_q  <= 1'b1;
        end
    end

    axis_skid_buf #(.WIDTH(BEAT_W)) u_buf0 (
        .clk       (aclk),
        .rst_n     (aresetn),
        .s_valid_i (b0_push),
        .s_ready_o (b0_ready),
        .s_data_i  (s_beat),
        .m_valid_o (m0_axis_tvalid),
        .m_ready_i (m0_axis_tready),
        .m_data_o  (m0_beat)
    );

    axis_skid_buf #(.WIDTH(BEAT_W)) u_buf1 (
        .clk       (aclk),
        .rst_n     (aresetn),
        .s_valid_i (b1_push),
        .s_ready_o (b1_ready),
        .s_data_i  (s_beat),
        .m_valid_o (m1_axis_tvalid),
        .m_ready_i (m1_axis_tready),
        .m_data_o  (m1_beat)
    );

    assign m0_axis_tdata = m0_beat.tdata;
    assign m0_axis_tuser = m0_beat.tuser;
    assign m0_axis_tlast = m0_beat.tlast;
    assign m0_axis_tstrb = m0_beat.tstrb;
    assign m0_axis_tkeep = m0_beat.tkeep;
    assign m0_axis_tid   = m0_beat.tid;
    assign m0_axis_tdest = m0_beat.tdest;

    assign m1_axis_tdata = m1_beat.tdata;
    assign m1_axis_tuser = m1_beat.tuser;
    assign m1_axis_tlast = m1_beat.tlast;
    assign m1_axis_tstrb = m1_beat.tstrb;
    assign m1_axis_tkeep = m1_beat.tkeep;
    assign m1_axis_tid   = m1_beat.tid;
    assign m1_axis_tdest = m1_beat.tdest;

endmodule
`default_nettype wire

// File: tb/tb_axis_demux_1x2.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// tb_axis_demux_1x2 : directed self-checking bench for axis_demux_1x2
// Revision 1.0      : initial release
// ----------------------------------------------------------------------------
module tb_axis_demux_1x2;

    localparam int DATAW = 24;

    logic             aclk = 1'b0;
    logic             aresetn, sel, m0_en, m1_en;
    logic [DATAW-1:0] s_tdata;
    logic             s_tvalid, s_tready, s_tuser, s_tlast, s_tid, s_tdest;
    logic [2:0]       s_tstrb, s_tkeep;
    logic [DATAW-1:0] m0_tdata, m1_tdata;
    logic             m0_tvalid, m0_tready, m0_tuser, m0_tlast, m0_tid, m0_tdest;
    logic             m1_tvalid, m1_tready, m1_tuser, m1_tlast, m1_tid, m1_tdest;
    logic [2:0]       m0_tstrb, m0_tkeep, m1_tstrb, m1_tkeep;
    logic             busy;
    logic [15:0]      drop_cnt;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;
    int w;

    always #5 aclk = ~aclk;

    axis_demux_1x2 #(.DATAW(DATAW)) dut (
        .aclk(aclk), .aresetn(aresetn), .sel(sel), .m0_en(m0_en), .m1_en(m1_en),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
        .s_axis_tuser(s_tuser), .s_axis_tlast(s_tlast), .s_axis_tstrb(s_tstrb),
        .s_axis_tkeep(s_tkeep), .s_axis_tid(s_tid), .s_axis_tdest(s_tdest),
        .m0_axis_tdata(m0_tdata), .m0_axis_tvalid(m0_tvalid), .m0_axis_tready(m0_tready),
        .m0_axis_tuser(m0_tuser), .m0_axis_tlast(m0_tlast), .m0_axis_tstrb(m0_tstrb),
        .m0_axis_tkeep(m0_tkeep), .m0_axis_tid(m0_tid), .m0_axis_tdest(m0_tdest),
        .m1_axis_tdata(m1_tdata), .m1_axis_tvalid(m1_tvalid), .m1_axis_tready(m1_tready),
        .m1_axis_tuser(m1_tuser), .m1_axis_tlast(m1_tlast), .m1_axis_tstrb(m1_tstrb),
        .m1_axis_tkeep(m1_tkeep), .m1_axis_tid(m1_tid), .m1_axis_tdest(m1_tdest),
        .busy(busy), .drop_cnt(drop_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Side-band fields are derived from tdata so bit-exact passage is visible.
    function automatic logic [33:0] exp_pay(input logic [23:0] d, input logic last);
        return {d, d[0], last, d[2:0] ^ 3'b101, d[5:3], d[1], d[2]};
    endfunction

    function automatic logic [33:0] m0_pay();
        return {m0_tdata, m0_tuser, m0_tlast, m0_tstrb, m0_tkeep, m0_tid, m0_tdest};
    endfunction

    function automatic logic [33:0] m1_pay();
        return {m1_tdata, m1_tuser, m1_tlast, m1_tstrb, m1_tkeep, m1_tid, m1_tdest};
    endfunction

    task automatic set_beat(input logic [23:0] d, input logic last);
        s_tdata  = d;
        s_tuser  = d[0];
        s_tlast  = last;
        s_tstrb  = d[2:0] ^ 3'b101;
        s_tkeep  = d[5:3];
        s_tid    = d[1];
        s_tdest  = d[2];
        s_tvalid = 1'b1;
    endtask

    // Presents one beat, waits (bounded) for acceptance, returns cycles stalled.
    task automatic send(input logic [23:0] d, input logic last, output int waits);
        logic acc;
        acc   = 1'b0;
        waits = 0;
        set_beat(d, last);
        for (int i = 0; i < 20; i++) begin
            if (s_tready) begin
                acc = 1'b1;
                @(posedge aclk); #1;
                break;
            end
            waits++;
            @(posedge aclk); #1;
        end
        s_tvalid = 1'b0;
        chk("send_accept", acc, 1'b1);
    endtask

    initial begin
        aresetn = 1'b0; sel = 1'b0; m0_en = 1'b1; m1_en = 1'b1;
        m0_tready = 1'b1; m1_tready = 1'b1;
        s_tvalid = 1'b0; s_tdata = '0; s_tuser = 1'b0; s_tlast = 1'b0;
        s_tstrb = '0; s_tkeep = '0; s_tid = 1'b0; s_tdest = 1'b0;

        repeat (2) @(posedge aclk);
        #1;
        chk("rst_m0_tvalid", m0_tvalid, 1'b0);
        chk("rst_m1_tvalid", m1_tvalid, 1'b0);
        chk("rst_s_tready", s_tready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_drop_cnt", drop_cnt, 16'd0);
        aresetn = 1'b1;
        @(posedge aclk); #1;

        // 4-beat packet to m0, one-cycle latency
        sel = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            send(24'(i), (i == 4), w);
            chk("p4_m0_tvalid", m0_tvalid, 1'b1);
            chk("p4_m0_payload", m0_pay(), exp_pay(24'(i), (i == 4)));
            chk("p4_m1_tvalid", m1_tvalid, 1'b0);
            chk("p4_busy", busy, (i != 4));
        end
        @(posedge aclk); #1;
        chk("p4_drained", m0_tvalid, 1'b0);

        // sel flipped mid-packet: packet stays on m0, next goes to m1
        send(24'h000010, 1'b0, w);
        chk("sel_b1_m0", m0_pay(), exp_pay(24'h000010, 1'b0));
        sel = 1'b1;
        send(24'h000011, 1'b0, w);
        chk("sel_b2_m0", m0_pay(), exp_pay(24'h000011, 1'b0));
        chk("sel_b2_m1v", m1_tvalid, 1'b0);
        send(24'h000012, 1'b1, w);
        chk("sel_b3_m0", m0_pay(), exp_pay(24'h000012, 1'b1));
        chk("sel_b3_m1v", m1_tvalid, 1'b0);
        send(24'h000020, 1'b0, w);
        chk("sel_n1_m1v", m1_tvalid, 1'b1);
        chk("sel_n1_m1", m1_pay(), exp_pay(24'h000020, 1'b0));
        chk("sel_n1_m0v", m0_tvalid, 1'b0);
        send(24'h000021, 1'b1, w);
        chk("sel_n2_m1", m1_pay(), exp_pay(24'h000021, 1'b1));
        @(posedge aclk); #1;

        // Two 2-beat packets to a disabled m1 are dropped
        m1_en = 1'b0;
        for (int p = 0; p < 2; p++) begin
            for (int b = 0; b < 2; b++) begin
                chk("drop_s_tready", s_tready, 1'b1);
                send(24'h000100 + 24'(2 * p + b), (b == 1), w);
                chk("drop_m0_tvalid", m0_tvalid, 1'b0);
                chk("drop_m1_tvalid", m1_tvalid, 1'b0);
            end
        end
        chk("drop_cnt_2", drop_cnt, 16'd2);
        chk("drop_busy", busy, 1'b0);
        m1_en = 1'b1;

        // m0 backpressure for 5 cycles mid-packet
        sel = 1'b0;
        send(24'h000030, 1'b0, w);
        chk("bp_c0", m0_pay(), exp_pay(24'h000030, 1'b0));
        m0_tready = 1'b0;
        set_beat(24'h000031, 1'b0);
        chk("bp_ready_1slot", s_tready, 1'b1);
        @(posedge aclk); #1;
        set_beat(24'h000032, 1'b0);
        for (int c = 0; c < 5; c++) begin
            chk("bp_s_tready_low", s_tready, 1'b0);
            chk("bp_head_hold", m0_tdata, 24'h000030);
            if (c < 4) begin
                @(posedge aclk); #1;
            end
        end
        m0_tready = 1'b1;
        @(posedge aclk); #1;
        chk("bp_rel_c1", m0_pay(), exp_pay(24'h000031, 1'b0));
        chk("bp_rel_ready", s_tready, 1'b1);
        @(posedge aclk); #1;
        chk("bp_rel_c2", m0_pay(), exp_pay(24'h000032, 1'b0));
        set_beat(24'h000033, 1'b1);
        @(posedge aclk); #1;
        s_tvalid = 1'b0;
        chk("bp_rel_c3", m0_pay(), exp_pay(24'h000033, 1'b1));
        chk("bp_busy_end", busy, 1'b0);
        @(posedge aclk); #1;

        // Single-beat packets alternating sel at full rate
        for (int i = 0; i < 6; i++) begin
            sel = (i % 2 == 1);
            send(24'h000040 + 24'(i), 1'b1, w);
            chk("alt_no_stall", w, 0);
            chk("alt_busy", busy, 1'b0);
            if (i % 2 == 1) begin
                chk("alt_m1", m1_pay(), exp_pay(24'h000040 + 24'(i), 1'b1));
                chk("alt_m1v", m1_tvalid, 1'b1);
                chk("alt_m0v", m0_tvalid, 1'b0);
            end else begin
                chk("alt_m0", m0_pay(), exp_pay(24'h000040 + 24'(i), 1'b1));
                chk("alt_m0v", m0_tvalid, 1'b1);
                chk("alt_m1v", m1_tvalid, 1'b0);
            end
        end
        @(posedge aclk); #1;

        // Reset mid-packet with two beats buffered
        sel = 1'b0;
        m0_tready = 1'b0;
        send(24'h000050, 1'b0, w);
        send(24'h000051, 1'b0, w);
        chk("mr_m0v", m0_tvalid, 1'b1);
        chk("mr_head", m0_tdata, 24'h000050);
        chk("mr_full", s_tready, 1'b0);
        chk("mr_busy", busy, 1'b1);
        chk("mr_drop_before", drop_cnt, 16'd2);
        #2 aresetn = 1'b0;
        #1;
        chk("mr_m0_tvalid", m0_tvalid, 1'b0);
        chk("mr_m1_tvalid", m1_tvalid, 1'b0);
        chk("mr_drop_cnt", drop_cnt, 16'd0);
        chk("mr_busy_low", busy, 1'b0);
        chk("mr_s_tready", s_tready, 1'b0);
        #2 aresetn = 1'b1;
        @(posedge aclk); #1;
        sel = 1'b1;
        m0_tready = 1'b1;
        send(24'h000060, 1'b1, w);
        chk("mr_next_m1v", m1_tvalid, 1'b1);
        chk("mr_next_m1", m1_pay(), exp_pay(24'h000060, 1'b1));
        chk("mr_next_m0v", m0_tvalid, 1'b0);
        chk("mr_next_busy", busy, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
